logdrop_window_seq: RTL and testbench

- Sequences a stream of samples through one logdropWindow instance (ABSTRACT_MODEL=0) by generating its window time index `i_t` internally.
- Accepts samples on a valid/ready input, applies the window function at the current index and presents the result on a registered valid/ready output with an end-of-window marker.
- Supports one-shot and continuous windowing, abort, and a completed-window counter.
- Sits between a sample source and downstream accumulation or analysis logic.

---
 rtl/logdrop_window_seq_if.sv | 31 +++
 rtl/logdrop_window_seq.sv | 136 +++++++++++++
 tb/tb_logdrop_window_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/logdrop_window_seq_if.sv
// Sample-in / windowed-sample-out handshake bundle for logdrop_window_seq.
interface logdrop_window_seq_if #(
  parameter int DATA_W = 8,
  parameter int WINLEN = 64,
  parameter int CNT_W  = 16,
  localparam int T_W   = $clog2(WINLEN)
);
  logic              i_start;
  logic              i_continuous;
  logic              i_abort;
  logic [DATA_W-1:0] i_x;
  logic              i_xValid;
  logic              o_xReady;
  logic [DATA_W-1:0] o_y;
  logic [T_W-1:0]    o_t;
  logic              o_yLast;
  logic              o_yValid;
  logic              i_yReady;
  logic              o_busy;
  logic [CNT_W-1:0]  o_windowCount;

  modport master (
    output i_start, i_continuous, i_abort, i_x, i_xValid, i_yReady,
    input  o_xReady, o_y, o_t, o_yLast, o_yValid, o_busy, o_windowCount
  );

  modport slave (
    input  i_start, i_continuous, i_abort, i_x, i_xValid, i_yReady,
    output o_xReady, o_y, o_t, o_yLast, o_yValid, o_busy, o_windowCount
  );
endinterface

// File: rtl/logdrop_window_seq.sv
// Window sequencer: steps an internal index through logdropWindow and registers
// each windowed sample onto a valid/ready output with an end-of-window marker.

// Log-drop window: gain is 2^-(T_W-1) at the edges and doubles each time the
// distance to the nearest edge (plus one) crosses a power of two.
module logdropWindow #(
  parameter int DATA_W         = 8,
  parameter int WINLEN         = 64,
  parameter int ABSTRACT_MODEL = 0,
  localparam int T_W           = $clog2(WINLEN)
) (
  input  logic [T_W-1:0]    i_t,
  input  logic [DATA_W-1:0] i_x,
  output logic [DATA_W-1:0] o_y
);
  logic [T_W-1:0] fold;
  logic [T_W-1:0] fold_p1;
  logic [T_W-1:0] msb;
  logic [T_W-1:0] shift;

  // Upper half mirrors onto the lower half so the window is symmetric.
  assign fold    = i_t[T_W-1] ? (T_W'(WINLEN - 1) - i_t) : i_t;
  assign fold_p1 = fold + T_W'(1);

  if (ABSTRACT_MODEL == 0) begin : g_penc
    always_comb begin
      msb = '0;
      for (int unsigned i = 0; i < T_W; i++) begin
        if (fold_p1[i]) msb = T_W'(i);
      end
    end
  end else begin : g_cmp
    always_comb begin
      msb = '0;
      for (int unsigned i = 1; i < T_W; i++) begin
        if (fold_p1 >= (T_W'(1) << i)) msb = T_W'(i);
      end
    end
  end

  assign shift = T_W'(T_W - 1) - msb;
  assign o_y   = i_x >> shift;
endmodule

module logdrop_window_seq #(
  parameter int DATA_W = 8,
  parameter int WINLEN = 64,
  parameter int CNT_W  = 16,
  localparam int T_W   = $clog2(WINLEN)
) (
  input logic i_clk,
  input logic i_rst,
  logdrop_window_seq_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [T_W-1:0]    t;
  logic [DATA_W-1:0] win_y;
  logic [DATA_W-1:0] y_q;
  logic [T_W-1:0]    t_q;
  logic              last_q;
  logic              valid_q;
  logic [CNT_W-1:0]  count_q;
  logic              accept;
  logic              take;
  logic              last_idx;

  logdropWindow #(
    .DATA_W(DATA_W),
    .WINLEN(WINLEN),
    .ABSTRACT_MODEL(0)
  ) u_window (
    .i_t(t),
    .i_x(bus.i_x),
    .o_y(win_y)
  );

  // Ready depends combinationally on downstream ready so a take and an
  // accept can share a cycle without a skid buffer.
  assign bus.o_xReady = (state == RUN) && !bus.i_abort && (!valid_q || bus.i_yReady);
  assign accept       = bus.i_xValid && bus.o_xReady;
  assign take         = valid_q && bus.i_yReady;
  assign last_idx     = (t == T_W'(WINLEN - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      t       <= '0;
      y_q     <= '0;
      t_q     <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      if (take) valid_q <= 1'b0;
      if (accept) begin
        y_q     <= win_y;
        t_q     <= t;
        last_q  <= last_idx;
        valid_q <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (bus.i_start && !bus.i_abort) begin
            state <= RUN;
            t     <= '0;
          end
        end
        RUN: begin
          if (bus.i_abort) begin
            state <= IDLE;
            t     <= '0;
          end else if (accept) begin
            if (last_idx) begin
              t <= '0;
              if (count_q != '1) count_q <= count_q + CNT_W'(1);
              if (!bus.i_continuous) state <= IDLE;
            end else begin
              t <= t + T_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_y           = y_q;
  assign bus.o_t           = t_q;
  assign bus.o_yLast       = last_q;
  assign bus.o_yValid      = valid_q;
  assign bus.o_busy        = (state == RUN) || valid_q;
  assign bus.o_windowCount = count_q;
endmodule

// File: tb/tb_logdrop_window_seq.sv
// Scoreboard bench for logdrop_window_seq with a small windowing model.
module tb_logdrop_window_seq;
  localparam int DATA_W = 5;
  localparam int WINLEN = 16;
  localparam int CNT_W  = 2;

  typedef struct {
    logic [DATA_W-1:0] y;
    int                t;
    logic              last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logdrop_window_seq_if #(.DATA_W(DATA_W), .WINLEN(WINLEN), .CNT_W(CNT_W)) bus ();

  logdrop_window_seq #(.DATA_W(DATA_W), .WINLEN(WINLEN), .CNT_W(CNT_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t sb[$];
  bit    m_run    = 1'b0;
  int    mt       = 0;
  int    m_cnt    = 0;
  int    n_acc    = 0;
  int    sat_exp[5] = '{1, 2, 3, 3, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_win(input int t, input logic [DATA_W-1:0] x);
    int d   = (t < WINLEN / 2) ? t : (WINLEN - 1 - t);
    int s   = $clog2(WINLEN) - 1;
    int thr = 2;
    while (d + 1 >= thr) begin
      s--;
      thr *= 2;
    end
    return x >> s;
  endfunction

  // One clock: check handshake outputs mid-cycle, score the beat, advance the model.
  task automatic tick();
    bit    ready_m, acc, take, run_pre;
    beat_t b;
    #2;
    run_pre = m_run;
    ready_m = m_run && !bus.i_abort && (sb.size() == 0 || bus.i_yReady);
    if (!rst) begin
      check("x_ready", bus.o_xReady, ready_m);
      check("y_valid", bus.o_yValid, sb.size() != 0);
      check("busy", bus.o_busy, m_run || sb.size() != 0);
    end
    acc  = !rst && ready_m && bus.i_xValid;
    take = !rst && sb.size() != 0 && bus.i_yReady;
    if (take) begin
      b = sb.pop_front();
      check("y", bus.o_y, b.y);
      check("t", bus.o_t, b.t);
      check("y_last", bus.o_yLast, b.last);
    end
    if (acc) begin
      b.y = ref_win(mt, bus.i_x);
      b.t = mt;
      b.last = (mt == WINLEN - 1);
      sb.push_back(b);
      n_acc++;
      if (mt == WINLEN - 1) begin
        mt = 0;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!bus.i_continuous) m_run = 1'b0;
      end else begin
        mt++;
      end
    end
    if (!run_pre && bus.i_start && !bus.i_abort) begin
      m_run = 1'b1;
      mt = 0;
    end else if (run_pre && bus.i_abort) begin
      m_run = 1'b0;
      mt = 0;
    end
    if (rst) begin
      m_run = 1'b0;
      mt = 0;
      m_cnt = 0;
      sb.delete();
    end
    @(posedge clk);
    #1;
    check("win_count", bus.o_windowCount, m_cnt);
  endtask

  task automatic run_until(input int target, input bit rnd);
    int budget = 200;
    while (n_acc < target && budget > 0) begin
      if (rnd) bus.i_x = DATA_W'($urandom);
      tick();
      budget--;
    end
    check("acc_reached", n_acc, target);
  endtask

  task automatic do_reset();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_acc = 0;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] held_y;
    bus.i_start      = 1'b0;
    bus.i_continuous = 1'b0;
    bus.i_abort      = 1'b0;
    bus.i_x          = '0;
    bus.i_xValid     = 1'b1;
    bus.i_yReady     = 1'b1;

    // Reset with valid asserted, then idle: nothing may be accepted.
    do_reset();
    check("rst_x_ready", bus.o_xReady, 0);
    check("rst_y_valid", bus.o_yValid, 0);
    check("rst_count", bus.o_windowCount, 0);
    check("rst_busy", bus.o_busy, 0);
    tick();
    tick();
    check("idle_no_accept", bus.o_yValid, 0);

    // One-shot window of constant full-scale samples.
    do_reset();
    bus.i_xValid = 1'b0;
    pulse_start();
    bus.i_x = 5'h1F;
    bus.i_xValid = 1'b1;
    run_until(16, 1'b0);
    check("no_17th_ready", bus.o_xReady, 0);
    tick();
    bus.i_xValid = 1'b0;
    check("oneshot_count", bus.o_windowCount, 1);
    check("oneshot_idle", bus.o_busy, 0);

    // Continuous run of 40 samples; a stray start mid-window is ignored.
    do_reset();
    bus.i_continuous = 1'b1;
    bus.i_xValid = 1'b0;
    pulse_start();
    bus.i_xValid = 1'b1;
    run_until(20, 1'b1);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    run_until(40, 1'b1);
    bus.i_xValid = 1'b0;
    check("cont_count", bus.o_windowCount, 2);
    check("cont_busy", bus.o_busy, 1);
    bus.i_continuous = 1'b0;
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    tick();

    // Backpressure for three cycles with o_t=4 pending.
    do_reset();
    bus.i_xValid = 1'b0;
    pulse_start();
    bus.i_xValid = 1'b1;
    run_until(5, 1'b1);
    held_y = bus.o_y;
    bus.i_yReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_y", bus.o_y, held_y);
      check("bp_hold_t", bus.o_t, 4);
      check("bp_hold_last", bus.o_yLast, 0);
    end
    bus.i_yReady = 1'b1;
    run_until(16, 1'b1);
    bus.i_xValid = 1'b0;
    tick();

    // Abort at t=9 with o_t=8 pending and a sample offered.
    do_reset();
    bus.i_xValid = 1'b0;
    pulse_start();
    bus.i_xValid = 1'b1;
    run_until(9, 1'b1);
    bus.i_abort = 1'b1;
    bus.i_yReady = 1'b0;
    tick();
    check("abort_pending_t", bus.o_t, 8);
    bus.i_abort = 1'b0;
    bus.i_yReady = 1'b1;
    tick();
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    check("abort_count", bus.o_windowCount, 0);
    bus.i_xValid = 1'b0;
    pulse_start();
    bus.i_xValid = 1'b1;
    run_until(n_acc + 1, 1'b1);
    bus.i_xValid = 1'b0;
    tick();

    // Counter saturation with a 2-bit counter.
    do_reset();
    for (int w = 0; w < 5; w++) begin
      bus.i_xValid = 1'b0;
      pulse_start();
      bus.i_xValid = 1'b1;
      run_until((w + 1) * 16, 1'b1);
      bus.i_xValid = 1'b0;
      tick();
      check("sat_count", bus.o_windowCount, sat_exp[w]);
    end

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
